// File: rtl/run_monitor.sv
// run_monitor: run controller and monitor for one or more single-cycle RISC-V cores.
// A start pulse arms a run. The block latches each core's halt, counts each core's
// execution cycles and the total RUN cycles, and reports DONE once every core has
// halted. It reports TIMEOUT if the watchdog expires first.
//
// Optional feature: define RUN_MON_SIG_EN to build per-core PC signature registers.
// When it is undefined, o_sig is tied to zero and no signature registers exist.
//
// Ports:
//   i_clk          clock; all state changes on its rising edge
//   i_rst          synchronous, active-high reset
//   i_start        1-cycle pulse; arms a run from IDLE, DONE or TOUT
//   i_halt         per-core halt flag, bit i belongs to core i
//   i_pc           per-core PC, core i at [i*PC_W +: PC_W]
//   o_busy         1 while in RUN
//   o_done         1 while in DONE
//   o_timeout      1 while in TOUT
//   o_halted_mask  sticky per-core halt latches
//   o_cycles       per-core cycle counts, core i at [i*CNT_W +: CNT_W]
//   o_total_cycles RUN cycles elapsed in the current or last run
//   o_sig          per-core PC signature, core i at [i*PC_W +: PC_W]
module run_monitor #(
    parameter int unsigned NUM_CORES = 1,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned TIMEOUT   = 100000,
    parameter int unsigned PC_W      = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [NUM_CORES-1:0]       i_halt,
    input  logic [NUM_CORES*PC_W-1:0]  i_pc,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_timeout,
    output logic [NUM_CORES-1:0]       o_halted_mask,
    output logic [NUM_CORES*CNT_W-1:0] o_cycles,
    output logic [CNT_W-1:0]           o_total_cycles,
    output logic [NUM_CORES*PC_W-1:0]  o_sig
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_TOUT} state_t;

    localparam logic [CNT_W-1:0] L_CNT_MAX   = '1;
    // total_cycles value at which the next RUN edge reaches the watchdog limit
    localparam logic [CNT_W-1:0] L_TOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                     r_state;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_timeout;
    logic [NUM_CORES-1:0]       r_mask;
    logic [NUM_CORES*CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0]           r_total;

    logic w_all_halted;
    logic w_tout_hit;

    // Halts arriving this cycle count toward completion, so DONE beats the watchdog.
    assign w_all_halted = &(r_mask | i_halt);
    assign w_tout_hit   = (r_total == L_TOUT_LAST);

`ifdef RUN_MON_SIG_EN
    logic [NUM_CORES*PC_W-1:0] r_sig;
`endif

    // Run FSM plus per-core latches and counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_mask    <= '0;
            r_cycles  <= '0;
            r_total   <= '0;
`ifdef RUN_MON_SIG_EN
            r_sig     <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_TOUT: begin
                    // Arm or re-arm; results hold until start arrives.
                    if (i_start) begin
                        r_state   <= S_RUN;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_mask    <= '0;
                        r_cycles  <= '0;
                        r_total   <= '0;
`ifdef RUN_MON_SIG_EN
                        r_sig     <= '0;
`endif
                    end
                end
                S_RUN: begin
                    if (r_total != L_CNT_MAX) begin
                        r_total <= r_total + CNT_W'(1);
                    end
                    for (int unsigned i = 0; i < NUM_CORES; i++) begin
                        if (!r_mask[i]) begin
                            if (i_halt[i]) begin
                                r_mask[i] <= 1'b1;
                            end else begin
                                if (r_cycles[i*CNT_W +: CNT_W] != L_CNT_MAX) begin
                                    r_cycles[i*CNT_W +: CNT_W] <=
                                        r_cycles[i*CNT_W +: CNT_W] + CNT_W'(1);
                                end
`ifdef RUN_MON_SIG_EN
                                // Rotate left by one, then fold in the current PC.
                                r_sig[i*PC_W +: PC_W] <=
                                    {r_sig[i*PC_W +: PC_W-1], r_sig[i*PC_W + PC_W-1]}
                                    ^ i_pc[i*PC_W +: PC_W];
`endif
                            end
                        end
                    end
                    if (w_all_halted) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_tout_hit) begin
                        r_state   <= S_TOUT;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_timeout      = r_timeout;
    assign o_halted_mask  = r_mask;
    assign o_cycles       = r_cycles;
    assign o_total_cycles = r_total;

`ifdef RUN_MON_SIG_EN
    assign o_sig = r_sig;
`else
    // PCs are only consumed by the signature logic.
    logic w_pc_unused;
    assign w_pc_unused = ^i_pc;
    assign o_sig       = '0;
`endif

endmodule
